// File: rtl/pc_gen_ras.sv
// Fetch PC generator with a small circular return-address stack.
// Redirect priority: trap, EX redirect, stall, predecoded call/return, sequential.
module pc_gen_ras #(
    parameter int unsigned           XLEN      = 32,
    parameter logic [XLEN-1:0]       RESET_VEC = 32'h0000_0000,
    parameter int unsigned           RAS_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             stall,
    input  logic                             trap_valid,
    input  logic [XLEN-1:0]                  trap_vector,
    input  logic                             ex_redirect,
    input  logic                             ex_is_jalr,
    input  logic [XLEN-1:0]                  ex_target,
    input  logic                             if_call,
    input  logic [XLEN-1:0]                  if_call_target,
    input  logic                             if_ret,
    output logic [XLEN-1:0]                  pc_out,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_overflow
);

    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            ovf_q, ovf_d;

    logic            wr_en;
    logic [PW-1:0]   wr_idx;
    logic [XLEN-1:0] wr_data;

    logic [XLEN-1:0] pc_seq;
    logic [PW-1:0]   top_idx;
    logic [XLEN-1:0] top_val;
    logic            ras_empty;
    logic            ras_full;

    // ptr_q is the next write slot; the top entry lives one below it (mod depth).
    assign pc_seq    = pc_q + XLEN'(4);
    assign top_idx   = ptr_q - PW'(1);
    assign top_val   = ras_mem[top_idx];
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CW'(RAS_DEPTH));

    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ovf_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        wr_data = pc_seq;

        if (trap_valid) begin
            pc_d  = {trap_vector[XLEN-1:2], 2'b00};
            cnt_d = '0;
            ptr_d = '0;
        end else if (ex_redirect) begin
            pc_d  = ex_is_jalr ? {ex_target[XLEN-1:1], 1'b0} : ex_target;
            cnt_d = '0;
            ptr_d = '0;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (if_call && if_ret) begin
            if (!ras_empty) begin
                // Tail call through a return: swap the top for the new link.
                pc_d   = top_val;
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end else begin
                pc_d  = pc_seq;
                wr_en = 1'b1;
                ptr_d = ptr_q + PW'(1);
                cnt_d = cnt_q + CW'(1);
            end
        end else if (if_call) begin
            pc_d  = if_call_target;
            wr_en = 1'b1;
            ptr_d = ptr_q + PW'(1);
            if (ras_full) begin
                // Full stack: the write slot holds the oldest entry, so it is overwritten.
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (if_ret) begin
            if (!ras_empty) begin
                pc_d  = top_val;
                ptr_d = top_idx;
                cnt_d = cnt_q - CW'(1);
            end else begin
                pc_d = pc_seq;
            end
        end else begin
            pc_d = pc_seq;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            cnt_q <= '0;
            ptr_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            ras_mem[wr_idx] <= wr_data;
        end
    end

    assign pc_out       = pc_q;
    assign ras_count    = cnt_q;
    assign ras_overflow = ovf_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Scoreboard bench for pc_gen_ras: a queue-based stack model predicts each cycle.
module tb_pc_gen_ras;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RVEC  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, trap_valid, ex_redirect, ex_is_jalr, if_call, if_ret;
    logic [31:0] trap_vector, ex_target, if_call_target;
    logic [31:0] pc_out;
    logic [2:0]  ras_count;
    logic        ras_overflow;

    pc_gen_ras #(
        .XLEN      (XLEN),
        .RESET_VEC (RVEC),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .trap_valid     (trap_valid),
        .trap_vector    (trap_vector),
        .ex_redirect    (ex_redirect),
        .ex_is_jalr     (ex_is_jalr),
        .ex_target      (ex_target),
        .if_call        (if_call),
        .if_call_target (if_call_target),
        .if_ret         (if_ret),
        .pc_out         (pc_out),
        .ras_count      (ras_count),
        .ras_overflow   (ras_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_stack[$];
    logic [31:0] m_pc;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RVEC;
        m_stack.delete();
    endtask

    // One clock: drive, predict, push; then after the edge pop and compare.
    task automatic step(input string tag, input bit trap, input logic [31:0] tv,
                        input bit redir, input bit jalr, input logic [31:0] tgt,
                        input bit stl, input bit call, input logic [31:0] ctgt,
                        input bit ret);
        exp_t        e;
        logic [31:0] seq;
        logic [31:0] t;
        logic        ovf;
        trap_valid = trap; trap_vector = tv; ex_redirect = redir; ex_is_jalr = jalr;
        ex_target = tgt; stall = stl; if_call = call; if_call_target = ctgt; if_ret = ret;
        seq = m_pc + 32'd4;
        ovf = 1'b0;
        if (trap) begin
            m_pc = {tv[31:2], 2'b00};
            m_stack.delete();
        end else if (redir) begin
            m_pc = jalr ? (tgt & 32'hFFFF_FFFE) : tgt;
            m_stack.delete();
        end else if (stl) begin
            m_pc = m_pc;
        end else if (call && ret) begin
            if (m_stack.size() > 0) begin
                t = m_stack.pop_back();
                m_stack.push_back(seq);
                m_pc = t;
            end else begin
                m_stack.push_back(seq);
                m_pc = seq;
            end
        end else if (call) begin
            if (m_stack.size() == DEPTH) begin
                void'(m_stack.pop_front());
                ovf = 1'b1;
            end
            m_stack.push_back(seq);
            m_pc = ctgt;
        end else if (ret) begin
            m_pc = (m_stack.size() > 0) ? m_stack.pop_back() : seq;
        end else begin
            m_pc = seq;
        end
        e.tag = tag; e.pc = m_pc; e.cnt = m_stack.size(); e.ovf = ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_pc"}, pc_out, e.pc);
            check({e.tag, "_cnt"}, {29'd0, ras_count}, e.cnt);
            check({e.tag, "_ovf"}, {31'd0, ras_overflow}, {31'd0, e.ovf});
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic redirect(input string tag, input logic [31:0] tgt);
        step(tag, 0, 0, 1, 0, tgt, 0, 0, 0, 0);
    endtask
    task automatic call(input string tag, input logic [31:0] tgt);
        step(tag, 0, 0, 0, 0, 0, 0, 1, tgt, 0);
    endtask
    task automatic ret(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_pc"}, pc_out, RVEC);
        check({tag, "_cnt"}, {29'd0, ras_count}, 32'd0);
        check({tag, "_ovf"}, {31'd0, ras_overflow}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        stall = 0; trap_valid = 0; trap_vector = 0; ex_redirect = 0; ex_is_jalr = 0;
        ex_target = 0; if_call = 0; if_call_target = 0; if_ret = 0;
        model_reset();
        #1;
        reset_check("rst0");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Free-running sequential fetch.
        idle("seq1"); idle("seq2"); idle("seq3");
        check("seq_lit", pc_out, 32'h10C);

        // Basic call / return pair.
        redirect("to200", 32'h200);
        call("call800", 32'h800);
        check("call_lit", pc_out, 32'h800);
        idle("body");
        ret("ret204");
        check("ret_lit", pc_out, 32'h204);

        // Five nested calls overflow a depth-4 stack; five returns unwind it.
        redirect("to0", 32'h0);
        for (int i = 1; i <= 5; i++) call($sformatf("nest%0d", i), 32'(i * 16));
        for (int i = 1; i <= 5; i++) ret($sformatf("unw%0d", i));
        check("unw_lit", pc_out, 32'h18);

        // Trap beats redirect beats stall; JALR clears bit 0.
        call("pre_trap", 32'h600);
        step("trap", 1, 32'h1007, 1, 1, 32'h333, 1, 1, 32'h900, 0);
        check("trap_lit", pc_out, 32'h1004);
        call("pre_jalr", 32'h700);
        step("jalr", 0, 0, 1, 1, 32'h333, 1, 0, 0, 1);
        check("jalr_lit", pc_out, 32'h332);

        // Stall holds PC and stack; call taken once after release.
        redirect("to40", 32'h40);
        call("call50", 32'h50);
        for (int i = 0; i < 3; i++) step($sformatf("stl%0d", i), 0, 0, 0, 0, 0, 1, 1, 32'h90, 0);
        check("stl_lit", pc_out, 32'h50);
        call("rel", 32'h90);
        idle("after_rel");

        // Simultaneous call + return, both with and without stack entries.
        call("cr_pre", 32'hA00);
        step("cr_swap", 0, 0, 0, 0, 0, 0, 1, 32'hB00, 1);
        ret("cr_ret");
        redirect("cr_flush", 32'hC00);
        step("cr_empty", 0, 0, 0, 0, 0, 0, 1, 32'hD00, 1);
        ret("cr_ret2");
        ret("ret_empty");

        // Address wrap.
        redirect("toTop", 32'hFFFF_FFFC);
        idle("wrap");
        check("wrap_lit", pc_out, 32'h0);

        // Asynchronous reset between edges.
        #3 rst = 1'b1;
        #1 reset_check("arst");
        rst = 1'b0;
        model_reset();
        idle("post_arst");

        // Reset while full and stalled discards everything.
        for (int i = 0; i < 4; i++) call($sformatf("fill%0d", i), 32'(32'h400 + i * 32'h40));
        trap_valid = 0; ex_redirect = 0; stall = 1; if_call = 1; if_ret = 0;
        #3 rst = 1'b1;
        #1 reset_check("arst_full");
        rst = 1'b0;
        model_reset();
        idle("post_full");
        check("post_full_lit", pc_out, RVEC + 32'd4);

        // Random mix against the model.
        for (int i = 0; i < 300; i++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            step("rnd", r == 0, $urandom, r == 1, $urandom_range(0, 1) == 1, $urandom,
                 r inside {[2:3]}, r inside {[4:7], 12}, {$urandom_range(0, 255), 2'b00},
                 r inside {[8:11], 12});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen_ras.md
PC_GEN_RAS -- requirements
Module: pc_gen_ras

Interface
REQ-001 Parameter XLEN, default 32: width of PC and all address ports.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 Parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, >=2.
REQ-004 Port clk  input  1  clock, rising-edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port stall  input  1  hold PC and RAS this cycle.
REQ-007 Port trap_valid  input  1  trap/exception redirect request.
REQ-008 Port trap_vector  input  XLEN  trap handler address.
REQ-009 Port ex_redirect  input  1  EX-stage branch/JAL/JALR redirect.
REQ-010 Port ex_is_jalr  input  1  qualifies ex_redirect as JALR.
REQ-011 Port ex_target  input  XLEN  EX-stage redirect target.
REQ-012 Port if_call  input  1  predecoded: instruction at pc_out is a call (link rd=x1/x5).
REQ-013 Port if_call_target  input  XLEN  predecoded call target.
REQ-014 Port if_ret  input  1  predecoded: instruction at pc_out is a return.
REQ-015 Port pc_out  output  XLEN  current fetch PC, driven from register.
REQ-016 Port ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries.
REQ-017 Port ras_overflow  output  1  registered one-cycle pulse: push occurred while full.

Function
REQ-018 Next-PC priority SHALL be: trap_valid > ex_redirect > stall > if_ret/if_call > pc_out+4.
REQ-019 trap_valid SHALL load pc_out <= {trap_vector[XLEN-1:2],2'b00}, flush RAS (ras_count<=0), regardless of stall.
REQ-020 ex_redirect (no trap) SHALL load pc_out <= ex_target, with bit0 cleared when ex_is_jalr=1; RAS flushed; stall ignored.
REQ-021 stall (no trap/redirect) SHALL hold pc_out, RAS contents, ras_count; if_call/if_ret ignored.
REQ-022 if_call only: push pc_out+4, pc_out <= if_call_target.
REQ-023 if_ret only, ras_count>0: pop; pc_out <= popped top.
REQ-024 if_ret only, ras_count==0: no RAS change; pc_out <= pc_out+4.
REQ-025 if_call and if_ret together, ras_count>0: pc_out <= old top; top replaced by pc_out+4; ras_count unchanged.
REQ-026 if_call and if_ret together, ras_count==0: push pc_out+4; pc_out <= pc_out+4.
REQ-027 RAS SHALL be circular: push at ras_count==RAS_DEPTH overwrites oldest entry, ras_count stays RAS_DEPTH, ras_overflow pulses 1 next cycle.
REQ-028 ras_overflow SHALL be 0 in every cycle not following an overflowing push.
REQ-029 All PC arithmetic SHALL be modulo 2^XLEN; pc_out+4 wraps from all-ones region to low addresses without error.
REQ-030 Each state change SHALL take effect at the next rising clk edge (1-cycle latency, no combinational input->pc_out path).
REQ-031 RAS entries SHALL not require reset; only ras_count and top pointer are reset.

Reset
REQ-032 rst=1 SHALL immediately force pc_out=RESET_VEC, ras_count=0, ras_overflow=0, top pointer=0, independent of clk.
REQ-033 Reset asserted mid-operation (during stall, redirect or full RAS) SHALL discard all pending state; first post-reset edge with no requests gives pc_out=RESET_VEC+4.

Verification
REQ-034 Reset RESET_VEC=32'h100, 3 free-running cycles -> pc_out 0x100,0x104,0x108,0x10C; ras_count=0.
REQ-035 pc_out=0x200, if_call, if_call_target=0x800 -> pc_out=0x800, ras_count=1; later if_ret -> pc_out=0x204, ras_count=0.
REQ-036 RAS_DEPTH=4, five calls from 0x0,0x10,0x20,0x30,0x40 (targets = next caller PCs) -> ras_count=4, ras_overflow pulse after 5th; five rets -> 0x44,0x34,0x24,0x14, then pc+4 fallthrough.
REQ-037 Same cycle stall=1, ex_redirect=1, ex_is_jalr=1, ex_target=0x333, trap_valid=1, trap_vector=0x1007 -> pc_out=0x1004, ras_count=0; repeat without trap -> pc_out=0x332.
REQ-038 stall=1 with if_call=1 for 3 cycles at pc_out=0x50 -> pc_out stays 0x50, ras_count unchanged; release -> call taken once.
REQ-039 XLEN=32, pc_out=0xFFFF_FFFC, no requests -> pc_out=0x0000_0000; async rst pulse between edges -> pc_out=RESET_VEC before next edge.
